// File: rtl/uart_msg_arbiter_if.sv
// Byte-stream bundle between message requesters, the arbiter and uart_tx.
// master is the arbiter side, slave is the requester/uart side.
interface uart_msg_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   abort;
  logic                 busy;
  logic [7:0]           tx_data;
  logic                 tx_data_valid;
  logic                 tx_data_ready;

  modport master (
    input  req_data,
    input  req_valid,
    input  req_last,
    output req_ready,
    output grant,
    output abort,
    output busy,
    output tx_data,
    output tx_data_valid,
    input  tx_data_ready
  );

  modport slave (
    output req_data,
    output req_valid,
    output req_last,
    input  req_ready,
    input  grant,
    input  abort,
    input  busy,
    input  tx_data,
    input  tx_data_valid,
    output tx_data_ready
  );
endinterface

// File: rtl/uart_msg_arbiter.sv
// Round-robin message arbiter: one requester owns uart_tx per message,
// released on its last byte or after a mid-message stall timeout.
module uart_msg_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int STALL_CYCLES = 1024
) (
  input logic            clk,
  input logic            rst_n,
  uart_msg_arbiter_if.master bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STALL_CYCLES + 2);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [SW-1:0] STALL_LIM =
    SW'(STALL_CYCLES > 0 ? STALL_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GAP_LIM =
    GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] abort_q, abort_d;
  logic [PW-1:0]      gidx_q, gidx_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [7:0]         data_q, data_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic [SW-1:0]      stall_q, stall_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic [PW-1:0]      pick;
  logic               found;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               msg_end;

  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // first valid requester at or above the pointer, wrapping
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[wrap_add(ptr_q, k)]) begin
        pick  = wrap_add(ptr_q, k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == PW'(i)) begin
        sel_data  = bus.req_data[i*8 +: 8];
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      abort_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      stall_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      abort_q <= abort_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    abort_d = '0;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    last_d  = last_q;
    stall_d = stall_q;
    gap_d   = gap_q;
    msg_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = NUM_REQ'(1) << pick;
          gidx_d  = pick;
          ptr_d   = wrap_add(pick, 1);
          stall_d = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (sel_valid && !vld_q) begin
          data_d  = sel_data;
          vld_d   = 1'b1;
          last_d  = sel_last;
          stall_d = '0;
        end else if (vld_q) begin
          // uart backpressure never feeds the stall counter
          if (bus.tx_data_ready) begin
            vld_d   = 1'b0;
            msg_end = last_q;
          end
        end else if (STALL_CYCLES != 0 &&
                     stall_q == STALL_LIM) begin
          abort_d = grant_q;
          msg_end = 1'b1;
        end else begin
          stall_d = stall_q + SW'(1);
        end
        if (msg_end) begin
          grant_d = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LIM) state_d = IDLE;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready =
    (state_q == XFER && !vld_q) ? grant_q : '0;
  assign bus.grant         = grant_q;
  assign bus.abort         = abort_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.tx_data       = data_q;
  assign bus.tx_data_valid = vld_q;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Directed bench for uart_msg_arbiter: 4 requesters, 3-cycle gap,
// 8-cycle stall timeout.
module tb_uart_msg_arbiter;

  logic clk;
  logic rst_n;

  uart_msg_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_msg_arbiter #(
    .NUM_REQ     (4),
    .GAP_CYCLES  (3),
    .STALL_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int cyc;
  int mode;

  logic [8:0] mem [4][16];
  int head [4];
  int tail [4];

  logic [7:0] log_d [64];
  logic [3:0] log_g [64];
  logic [3:0] post_g [64];
  int n_log;
  int pend_idx;
  logic pend;

  int n_abort;
  logic [3:0] abort_val;
  logic [3:0] abort_gnt;
  int abort_cyc;
  int load_cyc;
  logic [3:0] prev_g;
  logic [3:0] rise_rdy;
  int fall_cyc;
  logic fall_seen;
  logic fall_busy;
  int gap_len;
  logic prev_vld;
  logic prev_acc;
  logic [7:0] prev_data;
  int unstable;

  logic [7:0] exp_d [8] =
    '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41};
  logic [3:0] exp_g [8] =
    '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    n_log     = 0;
    pend      = 1'b0;
    n_abort   = 0;
    abort_val = '0;
    abort_gnt = '0;
    abort_cyc = -1;
    load_cyc  = -1;
    prev_g    = '0;
    rise_rdy  = '0;
    fall_seen = 1'b0;
    fall_busy = 1'b0;
    gap_len   = -1;
    prev_vld  = 1'b0;
    prev_acc  = 1'b0;
    prev_data = '0;
    unstable  = 0;
  endtask

  task automatic push(input int r, input logic [7:0] d,
                      input logic l);
    mem[r][tail[r]] = {l, d};
    tail[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (head[i] < tail[i]) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[i*8 +: 8] = mem[i][head[i]][7:0];
        bus.req_last[i]        = mem[i][head[i]][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[i*8 +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
    case (mode)
      1:       bus.tx_data_ready = 1'b1;
      2:       bus.tx_data_ready = ((cyc % 20) == 19);
      default: bus.tx_data_ready = 1'b0;
    endcase
  endtask

  task automatic run(input int n);
    logic [3:0] fire;
    logic acc;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (pend) begin
        post_g[pend_idx] = bus.grant;
        pend = 1'b0;
      end
      if (prev_vld && !prev_acc && bus.tx_data !== prev_data)
        unstable++;
      acc = bus.tx_data_valid && bus.tx_data_ready;
      if (acc && n_log < 64) begin
        log_d[n_log] = bus.tx_data;
        log_g[n_log] = bus.grant;
        pend_idx = n_log;
        pend = 1'b1;
        n_log++;
      end
      prev_vld  = bus.tx_data_valid;
      prev_acc  = acc;
      prev_data = bus.tx_data;
      fire = bus.req_valid & bus.req_ready;
      if (fire != 0) load_cyc = cyc;
      if (bus.abort != 0) begin
        n_abort++;
        abort_val = bus.abort;
        abort_gnt = bus.grant;
        abort_cyc = cyc;
      end
      if (bus.grant != 0 && prev_g == 0) begin
        rise_rdy = bus.req_ready;
        if (fall_seen) gap_len = cyc - fall_cyc;
      end
      if (bus.grant == 0 && prev_g != 0) begin
        fall_cyc  = cyc;
        fall_seen = 1'b1;
        fall_busy = bus.busy;
      end
      prev_g = bus.grant;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (fire[i]) head[i]++;
      cyc++;
      drive();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    mode  = 0;
    clear_all();
    rst_n = 1'b1;
    drive();
    #2 rst_n = 1'b0;
    #20;
    chk("rst_grant", bus.grant, 4'h0);
    chk("rst_abort", bus.abort, 4'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_txdata", bus.tx_data, 8'h00);
    chk("rst_txvalid", bus.tx_data_valid, 1'b0);
    chk("rst_ready", bus.req_ready, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single message "OK\n" from requester 1, slow uart
    clear_all();
    push(1, 8'h4F, 1'b0);
    push(1, 8'h4B, 1'b0);
    push(1, 8'h0A, 1'b1);
    mode = 2;
    drive();
    run(90);
    chk("ok_count", n_log, 3);
    chk("ok_d0", log_d[0], 8'h4F);
    chk("ok_d1", log_d[1], 8'h4B);
    chk("ok_d2", log_d[2], 8'h0A);
    chk("ok_g0", log_g[0], 4'h2);
    chk("ok_g1", log_g[1], 4'h2);
    chk("ok_g2", log_g[2], 4'h2);
    chk("ok_hold_g", post_g[0], 4'h2);
    chk("ok_end_g", post_g[2], 4'h0);
    chk("ok_ready_at_grant", rise_rdy, 4'h2);
    chk("ok_stable", unstable, 0);

    // all four requesters pending out of reset
    clear_all();
    for (int r = 0; r < 4; r++) begin
      push(r, 8'(8'h10 * (r + 1)), 1'b0);
      push(r, 8'(8'h10 * (r + 1) + 1), 1'b1);
    end
    mode = 1;
    rst_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(60);
    chk("rr_count", n_log, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_data%0d", i), log_d[i], exp_d[i]);
      chk($sformatf("rr_grant%0d", i), log_g[i], exp_g[i]);
    end

    // pointer wrapped to 0 after requester 3
    clear_all();
    push(2, 8'h60, 1'b1);
    push(0, 8'h50, 1'b1);
    drive();
    run(40);
    chk("wrap_count", n_log, 2);
    chk("wrap_d0", log_d[0], 8'h50);
    chk("wrap_g0", log_g[0], 4'h1);
    chk("wrap_d1", log_d[1], 8'h60);
    chk("wrap_g1", log_g[1], 4'h4);

    // requester 2 stalls after one non-last byte
    clear_all();
    push(2, 8'h70, 1'b0);
    drive();
    run(40);
    chk("stall_count", n_log, 1);
    chk("stall_d0", log_d[0], 8'h70);
    chk("stall_g0", log_g[0], 4'h4);
    chk("stall_abort_n", n_abort, 1);
    chk("stall_abort_val", abort_val, 4'h4);
    chk("stall_abort_gnt", abort_gnt, 4'h0);
    // load edge, one accept cycle, then 8 starved cycles
    chk("stall_abort_dly", abort_cyc - load_cyc, 10);

    // uart held off for 5000 cycles with a byte pending
    clear_all();
    push(1, 8'h80, 1'b1);
    mode = 0;
    drive();
    run(5000);
    chk("bp_abort_n", n_abort, 0);
    chk("bp_valid", bus.tx_data_valid, 1'b1);
    chk("bp_data", bus.tx_data, 8'h80);
    chk("bp_grant", bus.grant, 4'h2);
    chk("bp_stable", unstable, 0);
    mode = 1;
    drive();
    run(20);
    chk("bp_count", n_log, 1);
    chk("bp_d0", log_d[0], 8'h80);

    // gap between messages, pointer sits at 2
    clear_all();
    push(0, 8'h90, 1'b1);
    push(3, 8'hA0, 1'b1);
    drive();
    run(40);
    chk("gap_count", n_log, 2);
    chk("gap_d0", log_d[0], 8'hA0);
    chk("gap_g0", log_g[0], 4'h8);
    chk("gap_d1", log_d[1], 8'h90);
    chk("gap_g1", log_g[1], 4'h1);
    chk("gap_len", gap_len, 4);
    chk("gap_busy", fall_busy, 1'b1);

    // reset in the middle of a message
    clear_all();
    push(1, 8'hB0, 1'b0);
    push(1, 8'hB1, 1'b1);
    mode = 0;
    drive();
    run(6);
    chk("mid_valid", bus.tx_data_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_grant", bus.grant, 4'h0);
    chk("mid_abort", bus.abort, 4'h0);
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_txdata", bus.tx_data, 8'h00);
    chk("mid_txvalid", bus.tx_data_valid, 1'b0);
    chk("mid_ready", bus.req_ready, 4'h0);
    clear_all();
    push(1, 8'hC0, 1'b1);
    push(3, 8'hD0, 1'b1);
    mode = 1;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(40);
    chk("ptr_count", n_log, 2);
    chk("ptr_d0", log_d[0], 8'hC0);
    chk("ptr_g0", log_g[0], 4'h2);
    chk("ptr_d1", log_d[1], 8'hD0);
    chk("ptr_g1", log_g[1], 4'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
